uart_rx: RTL and testbench

UART receiver paired with uart_tx. Receives 8N1 frames (1 start, 8 data LSB-first, 1 stop) on serial input rx, samples each bit at its centre, and presents each received byte with a one-cycle valid strobe. It sits between the board RX/RS485 receiver pin and user logic. It uses the same baud parameters as uart_tx, so the two form a loopback-compatible pair.

---
 rtl/uart_rx.sv | 142 ++++++++++++++
 tb/tb_uart_rx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, samples each bit at its centre and
// strobes po_flag with the received byte or frame_err on a bad stop bit.
`timescale 1ns/1ps
module uart_rx #(
    parameter int UART_BPS = 9600,
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rx,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam int          BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam logic [15:0] CNT_LAST     = 16'(BAUD_CNT_MAX - 1);
    localparam logic [15:0] CNT_MID      = 16'(BAUD_CNT_MAX / 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        rx_meta_r;
    logic        rx_sync_r;
    logic        rx_dly_r;
    logic [15:0] baud_cnt_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  shift_r;
    logic [7:0]  po_data_r;
    logic        po_flag_r;
    logic        frame_err_r;
    logic        fall_s;
    logic        sample_en_s;
    logic        flag_nxt_s;
    logic        err_nxt_s;
    logic        busy_s;

    // Synchroniser and edge-detect flops reset high so reset release looks like idle line.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_dly_r  <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_dly_r  <= rx_sync_r;
        end
    end

    assign fall_s      = rx_dly_r & ~rx_sync_r;
    assign sample_en_s = (state_r != IDLE) && (baud_cnt_r == CNT_MID);

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; STOP exits at the stop-bit centre to leave margin for the next start.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (fall_s) state_nxt_s = START;
                else        state_nxt_s = IDLE;
            end
            START: begin
                if (sample_en_s) state_nxt_s = rx_sync_r ? IDLE : DATA;
                else             state_nxt_s = START;
            end
            DATA: begin
                if (sample_en_s && (bit_cnt_r == 3'd7)) state_nxt_s = STOP;
                else                                    state_nxt_s = DATA;
            end
            STOP: begin
                if (sample_en_s) state_nxt_s = IDLE;
                else             state_nxt_s = STOP;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Output decode: strobe requests for the next cycle and busy from state.
    always_comb begin
        flag_nxt_s = 1'b0;
        err_nxt_s  = 1'b0;
        busy_s     = (state_r != IDLE);
        if ((state_r == STOP) && sample_en_s) begin
            flag_nxt_s = rx_sync_r;
            err_nxt_s  = ~rx_sync_r;
        end else begin
            flag_nxt_s = 1'b0;
            err_nxt_s  = 1'b0;
        end
    end

    // Bit timing, data shifting and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            baud_cnt_r  <= 16'd0;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            po_data_r   <= 8'h00;
            po_flag_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if ((state_r == IDLE) || (baud_cnt_r == CNT_LAST)) begin
                baud_cnt_r <= 16'd0;
            end else begin
                baud_cnt_r <= baud_cnt_r + 16'd1;
            end
            if ((state_r == START) && sample_en_s) begin
                bit_cnt_r <= 3'd0;
            end else if ((state_r == DATA) && sample_en_s) begin
                bit_cnt_r <= bit_cnt_r + 3'd1;
                shift_r   <= {rx_sync_r, shift_r[7:1]};
            end
            if (flag_nxt_s) begin
                po_data_r <= shift_r;
            end
            po_flag_r   <= flag_nxt_s;
            frame_err_r <= err_nxt_s;
        end
    end

    assign po_data   = po_data_r;
    assign po_flag   = po_flag_r;
    assign frame_err = frame_err_r;
    assign rx_busy   = busy_s;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a serial-line driver pushes the expected
// strobe for every frame, a monitor pops and compares on each DUT strobe.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int UART_BPS = 9600;
    localparam int CLK_FREQ = 960_000;
    localparam int BIT_CLKS = CLK_FREQ / UART_BPS;
    localparam int MID      = BIT_CLKS / 2;
    localparam int LAT      = 3 + 9 * BIT_CLKS + MID + 1;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       rx        = 1'b1;
    logic [7:0] po_data;
    logic       po_flag;
    logic       frame_err;
    logic       rx_busy;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] last_good = 8'h00;
    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         start_cycle = 0;
    bit         lat_armed   = 1'b0;

    uart_rx #(.UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx        (rx),
        .po_data   (po_data),
        .po_flag   (po_flag),
        .frame_err (frame_err),
        .rx_busy   (rx_busy)
    );

    always #10 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic void check(string name, int act, int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Transmitter model: pushes the outcome the frame must produce, then drives it.
    task automatic send_frame(input logic [7:0] d, input int bclks, input bit stop_ok);
        exp_t e;
        e.is_err = !stop_ok;
        e.data   = stop_ok ? d : last_good;
        if (stop_ok) last_good = d;
        exp_q.push_back(e);
        rx = 1'b0;
        wait_clks(bclks);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(bclks);
        end
        rx = stop_ok;
        wait_clks(bclks);
        if (!stop_ok) begin
            wait_clks(bclks);
            rx = 1'b1;
            wait_clks(8);
        end
        rx = 1'b1;
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge sys_clk) begin
        exp_t e;
        int   lat;
        if (sys_rst_n && po_flag) begin
            check("err_with_flag", frame_err, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_flag", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind_flag", e.is_err, 0);
                check("po_data", po_data, e.data);
            end
            if (lat_armed) begin
                lat_armed = 1'b0;
                lat = cyc - start_cycle;
                vectors++;
                if (lat < LAT - 2 || lat > LAT + 2) begin
                    miscompares++;
                    $display("FAIL latency: got %0d, expected %0d +/-2", lat, LAT);
                end
            end
        end else if (sys_rst_n && frame_err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_frame_err", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind_err", e.is_err, 1);
                check("po_data_held", po_data, e.data);
            end
        end
    end

    initial begin
        #(60000 * 20);
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bclks;
        int gap;
        bit ok;
        logic [7:0] d;

        wait_clks(5);
        check("rst_po_data", po_data, 8'h00);
        check("rst_po_flag", po_flag, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_rx_busy", rx_busy, 0);
        sys_rst_n = 1'b1;
        wait_clks(20);

        // Single frame with latency measurement.
        start_cycle = cyc;
        lat_armed   = 1'b1;
        send_frame(8'h55, BIT_CLKS, 1'b1);
        wait_clks(30);
        check("lat_measured", lat_armed, 0);

        // Back-to-back frames, no idle gap.
        send_frame(8'hA3, BIT_CLKS, 1'b1);
        send_frame(8'h0F, BIT_CLKS, 1'b1);
        wait_clks(BIT_CLKS);

        // Start glitch shorter than half a bit.
        rx = 1'b0;
        wait_clks(20);
        rx = 1'b1;
        wait_clks(10);
        check("glitch_busy_mid", rx_busy, 1);
        wait_clks(40);
        check("glitch_busy_end", rx_busy, 0);
        wait_clks(BIT_CLKS);

        // Framing error with break, then recovery.
        send_frame(8'h3C, BIT_CLKS, 1'b1);
        send_frame(8'hC3, BIT_CLKS, 1'b0);
        wait_clks(BIT_CLKS);
        send_frame(8'h81, BIT_CLKS, 1'b1);
        wait_clks(10);
        check("after_err_po_data", po_data, 8'h81);

        // Reset during data bit 4 of 8'hFF.
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        rx = 1'b1;
        wait_clks(4 * BIT_CLKS + MID);
        sys_rst_n = 1'b0;
        wait_clks(3);
        check("midrst_rx_busy", rx_busy, 0);
        check("midrst_po_data", po_data, 8'h00);
        last_good = 8'h00;
        sys_rst_n = 1'b1;
        wait_clks(4 * BIT_CLKS);
        send_frame(8'h12, BIT_CLKS, 1'b1);
        wait_clks(BIT_CLKS);

        // Baud skew of +3% and -3%.
        send_frame(8'hE7, int'(real'(BIT_CLKS) / 1.03), 1'b1);
        wait_clks(BIT_CLKS);
        send_frame(8'hE7, int'(real'(BIT_CLKS) / 0.97), 1'b1);
        wait_clks(BIT_CLKS);

        // Randomised frames with small skew, random gaps and occasional bad stop bits.
        for (int n = 0; n < 8; n++) begin
            d     = 8'($urandom_range(0, 255));
            bclks = $urandom_range(BIT_CLKS - 2, BIT_CLKS + 2);
            ok    = ($urandom_range(0, 3) != 0);
            gap   = $urandom_range(0, 30);
            send_frame(d, bclks, ok);
            wait_clks(gap);
        end

        wait_clks(2 * BIT_CLKS);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
